// File: rtl/fft_input_buffer.sv
// Ping-pong frame buffer between the I/Q scrambler and the radix-2 DIT FFT core.
// Captures 2^LOG2N samples per bank and replays each full bank in bit-reversed order.
module fft_input_buffer #(
  parameter int LOG2N = 6,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [LOG2N-1:0] out_index,
  output logic             out_last,
  output logic             overflow,
  output logic [15:0]      frame_count
);

  localparam int N = 1 << LOG2N;

  localparam logic [LOG2N-1:0] PTR_LAST = '1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  logic [DW-1:0]    mem [2*N];
  logic             wr_bank;
  logic             rd_bank;
  logic [LOG2N-1:0] wr_ptr;
  logic [LOG2N-1:0] rd_ptr;
  logic [1:0]       full;
  logic [1:0]       state;

  logic             accept;
  logic             wr_done;
  logic             handshake;
  logic             rd_done;
  logic [LOG2N-1:0] wr_addr;
  logic [LOG2N-1:0] rd_next;
  logic [LOG2N:0]   rd_addr;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
    return r;
  endfunction

  // NOTE: every signal driven from always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    accept    = in_valid && !full[wr_bank];
    wr_addr   = in_sof ? '0 : wr_ptr;
    wr_done   = accept && !in_sof && (wr_ptr == PTR_LAST);
    handshake = out_valid && out_ready;
    rd_done   = handshake && out_last;
    rd_next   = '0;
    if (state == ST_STREAM) rd_next = rd_ptr + 1'b1;
    rd_addr   = {rd_bank, bitrev(rd_next)};
  end

  // NOTE: the sample array has no reset; stale contents are never read because the full flags are cleared.
  always_ff @(posedge clk) begin
    if (accept) mem[{wr_bank, wr_addr}] <= in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank  <= 1'b0;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      if (in_sof) begin
        wr_ptr <= LOG2N'(1);
      end else if (wr_ptr == PTR_LAST) begin
        wr_ptr  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_ptr <= wr_ptr + 1'b1;
      end
    end else if (in_valid) begin
      overflow <= 1'b1;
    end
  end

  // Set and clear never hit the same bank: the writer only fills an empty bank, the reader only frees a full one.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (wr_done) full[wr_bank] <= 1'b1;
      if (rd_done) full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rd_bank     <= 1'b0;
      rd_ptr      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_index   <= '0;
      out_last    <= 1'b0;
      frame_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (full[rd_bank]) begin
            state  <= ST_FETCH;
            rd_ptr <= '0;
          end
        end
        ST_FETCH: begin
          out_data  <= mem[rd_addr];
          out_index <= '0;
          out_last  <= 1'b0;
          out_valid <= 1'b1;
          state     <= ST_STREAM;
        end
        ST_STREAM: begin
          if (handshake) begin
            if (out_last) begin
              rd_bank     <= ~rd_bank;
              frame_count <= frame_count + 16'd1;
              out_valid   <= 1'b0;
              out_last    <= 1'b0;
              state       <= ST_IDLE;
            end else begin
              rd_ptr    <= rd_next;
              out_data  <= mem[rd_addr];
              out_index <= rd_next;
              out_last  <= (rd_next == PTR_LAST);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_input_buffer.sv
// Directed bench for fft_input_buffer at LOG2N=3: bit-reversed replay, backpressure,
// overflow, start-of-frame resync, mid-stream reset and back-to-back frames.
module tb_fft_input_buffer;

  localparam int LOG2N = 3;
  localparam int DW    = 16;
  localparam int N     = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic             in_sof;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [LOG2N-1:0] out_index;
  logic             out_last;
  logic             overflow;
  logic [15:0]      frame_count;

  fft_input_buffer #(.LOG2N(LOG2N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .overflow(overflow),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int br[N] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int q_data[$];
  int q_idx[$];
  int q_last[$];

  logic hold_pend = 1'b0;
  int   h_data, h_idx, h_last;
  logic gap_armed = 1'b0;
  int   gap_cnt = 0;
  int   gaps_seen = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor: records handshakes, checks hold stability under backpressure and the inter-frame gap.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
      gap_armed = 1'b0;
      gap_cnt   = 0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data",  int'(out_data),  h_data);
        check("hold_index", int'(out_index), h_idx);
        check("hold_last",  int'(out_last),  h_last);
      end
      hold_pend = out_valid && !out_ready;
      h_data = int'(out_data);
      h_idx  = int'(out_index);
      h_last = int'(out_last);
      if (gap_armed) begin
        if (out_valid) begin
          check("frame_gap", gap_cnt, 2);
          gaps_seen++;
          gap_armed = 1'b0;
        end else begin
          gap_cnt++;
        end
      end
      if (out_valid && out_ready) begin
        q_data.push_back(int'(out_data));
        q_idx.push_back(int'(out_index));
        q_last.push_back(int'(out_last));
        if (out_last) begin
          gap_armed = 1'b1;
          gap_cnt   = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    q_data.delete(); q_idx.delete(); q_last.delete();
    gaps_seen = 0;
  endtask

  task automatic feed(input int base, input int count);
    in_valid = 1'b1;
    for (int i = 0; i < count; i++) begin
      in_data = DW'(base + i);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_handshakes(input string tag, input int n, input int budget);
    int c = 0;
    while (q_data.size() < n && c < budget) begin
      step();
      c++;
    end
    check({tag, "_count"}, q_data.size(), n);
  endtask

  task automatic expect_frame(input string tag, input int off, input int base);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_data%0d", tag, i),  q_data[off+i], base + br[i]);
      check($sformatf("%s_index%0d", tag, i), q_idx[off+i],  i);
      check($sformatf("%s_last%0d", tag, i),  q_last[off+i], (i == N-1) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pat[6] = '{1, 0, 0, 1, 0, 1};

    // Reset state, then a single frame with full throughput and latency check.
    do_reset();
    check("rst_valid", int'(out_valid),   0);
    check("rst_data",  int'(out_data),    0);
    check("rst_index", int'(out_index),   0);
    check("rst_last",  int'(out_last),    0);
    check("rst_ovf",   int'(overflow),    0);
    check("rst_fc",    int'(frame_count), 0);
    out_ready = 1'b1;
    feed(0, 8);
    check("t1_lat0", int'(out_valid), 0);
    step();
    check("t1_lat1", int'(out_valid), 0);
    step();
    check("t1_lat2", int'(out_valid), 1);
    wait_handshakes("t1", 8, 50);
    expect_frame("t1", 0, 0);
    check("t1_fc",  int'(frame_count), 1);
    check("t1_ovf", int'(overflow),    0);

    // Same frame under an irregular ready pattern.
    do_reset();
    feed(0, 8);
    for (int c = 0; c < 200 && q_data.size() < 8; c++) begin
      out_ready = pat[c % 6] != 0;
      step();
    end
    out_ready = 1'b1;
    check("t2_count", q_data.size(), 8);
    expect_frame("t2", 0, 0);
    step();
    check("t2_fc", int'(frame_count), 1);

    // Both banks fill while stalled; the third frame is dropped.
    do_reset();
    in_valid = 1'b1;
    for (int v = 0; v < 24; v++) begin
      in_data = DW'(v);
      step();
      if (v == 15) check("t3_ovf_before", int'(overflow), 0);
      if (v == 16) check("t3_ovf_after",  int'(overflow), 1);
    end
    in_valid = 1'b0;
    check("t3_fc_stalled", int'(frame_count), 0);
    out_ready = 1'b1;
    wait_handshakes("t3", 16, 100);
    expect_frame("t3a", 0, 0);
    expect_frame("t3b", 8, 8);
    repeat (4) step();
    check("t3_idle_valid", int'(out_valid), 0);
    check("t3_no_extra",   q_data.size(),   16);
    check("t3_gaps",       gaps_seen,       1);
    check("t3_fc",         int'(frame_count), 2);
    check("t3_ovf_sticky", int'(overflow),  1);

    // Start-of-frame discards a partial frame.
    do_reset();
    out_ready = 1'b1;
    feed(0, 5);
    in_valid = 1'b1; in_sof = 1'b1; in_data = DW'(100);
    step();
    in_sof = 1'b0;
    for (int v = 101; v < 108; v++) begin
      in_data = DW'(v);
      step();
    end
    in_valid = 1'b0;
    wait_handshakes("t4", 8, 50);
    expect_frame("t4", 0, 100);
    repeat (4) step();
    check("t4_no_extra", q_data.size(), 8);
    check("t4_fc",       int'(frame_count), 1);
    check("t4_ovf",      int'(overflow), 0);

    // Reset in the middle of streaming.
    do_reset();
    out_ready = 1'b1;
    feed(50, 8);
    wait_handshakes("t5_pre", 3, 50);
    check("t5_pre0", q_data[0], 50);
    check("t5_pre1", q_data[1], 54);
    check("t5_pre2", q_data[2], 52);
    rst = 1'b1; out_ready = 1'b0;
    step();
    check("t5_valid", int'(out_valid),   0);
    check("t5_data",  int'(out_data),    0);
    check("t5_index", int'(out_index),   0);
    check("t5_last",  int'(out_last),    0);
    check("t5_ovf",   int'(overflow),    0);
    check("t5_fc0",   int'(frame_count), 0);
    rst = 1'b0;
    q_data.delete(); q_idx.delete(); q_last.delete();
    out_ready = 1'b1;
    feed(20, 8);
    wait_handshakes("t5", 8, 50);
    expect_frame("t5", 0, 20);
    repeat (4) step();
    check("t5_no_extra", q_data.size(), 8);
    check("t5_fc",       int'(frame_count), 1);

    // Four frames with two idle input cycles between them, matching the output frame period.
    do_reset();
    out_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      feed(200 + 8*f, 8);
      step();
      step();
    end
    wait_handshakes("t6", 32, 100);
    for (int f = 0; f < 4; f++) expect_frame($sformatf("t6f%0d", f), 8*f, 200 + 8*f);
    check("t6_gaps", gaps_seen, 3);
    check("t6_ovf",  int'(overflow), 0);
    check("t6_fc",   int'(frame_count), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_input_buffer.md
Name: fft_input_buffer

Overview:
- Ping-pong frame buffer directly downstream of the 16-bit I/Q scrambler.
- Collects 2^LOG2N scrambled complex samples per frame. Each sample is {I[15:8], Q[7:0]}, two's complement.
- Replays each frame in bit-reversed index order to the radix-2 DIT FFT core, using a valid/ready handshake.
- The upstream scrambler has no backpressure, so the buffer absorbs rate mismatch and flags any samples it drops.

Parameters:
- LOG2N, 6, log2 of frame length N (N = 64); legal range 3..10.
- DW, 16, sample width (packed I/Q).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  sample present on in_data (driven from scrambler en, delayed one cycle).
- in_data  input  DW  scrambled sample.
- in_sof  input  1  start-of-frame; qualified by in_valid.
- out_valid  output  1  out_data holds a valid sample.
- out_ready  input  1  FFT core accepts the sample.
- out_data  output  DW  sample in bit-reversed order.
- out_index  output  LOG2N  natural-order read counter, 0..N-1 (not the bit-reversed address).
- out_last  output  1  last sample of the frame.
- overflow  output  1  sticky: at least one input sample was dropped.
- frame_count  output  16  frames fully delivered; wraps modulo 2^16.

Behaviour:
- Reset: sets all of the following to 0 on the next edge.
  - outputs out_valid, out_data, out_index, out_last, overflow, frame_count.
  - internal wr_bank, wr_ptr, rd_bank, rd_ptr, full[1:0].
  - read FSM returns to IDLE.
  - A reset mid-frame discards all partial and complete frames. Memory contents need no clearing.
- Write side:
  - Writes occur when in_valid=1 and full[wr_bank]=0:
    - mem[wr_bank][wr_ptr] <= in_data, then wr_ptr increments.
    - When wr_ptr == N-1: full[wr_bank] <= 1, wr_bank toggles, wr_ptr <= 0.
  - in_sof=1 with an accepted sample: the sample is written at address 0 and wr_ptr <= 1. The partial frame is discarded. in_sof has no effect while in_valid=0.
  - in_valid=1 while full[wr_bank]=1: sample dropped, overflow <= 1, wr_ptr unchanged. in_sof on a dropped sample is ignored.
- Read FSM, states IDLE, FETCH, STREAM:
  - IDLE: when full[rd_bank]=1, go to FETCH with rd_ptr=0.
  - FETCH: issue synchronous RAM read at address bitrev(0), then go to STREAM. out_valid rises on the edge that enters STREAM.
  - STREAM:
    - out_data = mem[rd_bank][bitrev(rd_ptr)], out_index = rd_ptr, out_last = (rd_ptr == N-1).
    - Handshake (out_valid & out_ready): rd_ptr increments and the next sample is presented on the following edge. Throughput is 1 sample/cycle with no bubbles inside a frame.
    - out_valid=1 & out_ready=0: out_data, out_index, out_last held stable.
    - Handshake with out_last=1: full[rd_bank] <= 0, rd_bank toggles, frame_count increments, out_valid <= 0, out_last <= 0, go to IDLE.
- Latency:
  - Last sample of a frame written at edge E: out_valid first high after edge E+2, provided the FSM is idle.
  - Frame gap: out_valid is low for exactly 2 cycles between consecutive frames, even if the next bank is already full.
- Simultaneous events:
  - Last-sample handshake at the same edge an input sample targets the bank being freed: the freed flag takes effect after the edge, so that sample is dropped and overflow is set.
  - The write side completing a bank at the same edge the FSM is in IDLE: the FSM sees full on the next cycle.
  - Writes and reads always target different banks while a read is in progress. Only the full flags are shared.
- Bit reversal: bitrev(k) reverses the LOG2N bits of k, e.g. N=8, k=1 -> 4.

Test Plan:
- LOG2N=3, rst then in_valid=1 with data 0..7, out_ready=1 -> out_data 0,4,2,6,1,5,3,7; out_index 0..7; out_last only on 7; out_valid first high 2 edges after the write of 7; frame_count=1.
- Same stimulus with out_ready pattern 1,0,0,1,0,1... -> identical sequence, no duplicate or lost sample, out_data stable on every ready=0 cycle.
- out_ready=0, feed data 0..23 continuously -> samples 16..23 dropped, overflow=1 from the edge of sample 16; then out_ready=1 -> frames {0,4,2,6,1,5,3,7} and {8,12,10,14,9,13,11,15}, 2-cycle gap between them, frame_count=2, overflow stays 1.
- Feed 0..4, then in_sof with 100, then 101..107 -> single frame 100,104,102,106,101,105,103,107; values 0..4 never appear.
- rst asserted mid-stream after 3 output handshakes -> next cycle all outputs 0; then 8 new samples 20..27 -> clean frame 20,24,22,26,21,25,23,27 with frame_count=1.
- 4 back-to-back frames (32 samples) with out_ready=1 -> no overflow, 4 correct bit-reversed frames, each separated by exactly 2 low cycles of out_valid, frame_count=4.
